// File: rtl/clock_div_prog.sv
// Runtime-programmable integer clock divider with a one-cycle tick strobe.
// A newly loaded divisor waits for the current period to finish before it takes effect.
module clock_div_prog #(
   parameter int p_width       = 8,
   parameter int p_default_div = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [p_width-1:0] div_val,
   input  logic               div_load,
   output logic               clk_out,
   output logic               tick,
   output logic [p_width-1:0] div_cur,
   output logic               div_pending
);

   logic [p_width-1:0] count_q, count_d;
   logic [p_width-1:0] div_cur_q, div_cur_d;
   logic [p_width-1:0] pend_val_q, pend_val_d;
   logic               div_pending_q, div_pending_d;
   logic               clk_out_q, clk_out_d;
   logic [p_width-1:0] eff_val;
   logic [p_width-1:0] new_div;
   logic               wrap;
   logic               apply;
   logic [p_width:0]   half_d;

   always_comb begin
      eff_val       = (div_val == '0) ? p_width'(1) : div_val;
      wrap          = en && (count_q == div_cur_q - p_width'(1));
      // A paused divider has no period in progress, so a new divisor can land at once.
      apply         = (!en || wrap) && (div_load || div_pending_q);
      new_div       = div_load ? eff_val : pend_val_q;
      count_d       = count_q;
      div_cur_d     = div_cur_q;
      pend_val_d    = pend_val_q;
      div_pending_d = div_pending_q;
      if (apply) begin
         div_cur_d     = new_div;
         pend_val_d    = new_div;
         count_d       = '0;
         div_pending_d = 1'b0;
      end else begin
         if (div_load) begin
            pend_val_d    = eff_val;
            div_pending_d = 1'b1;
         end
         if (en) begin
            count_d = wrap ? '0 : count_q + p_width'(1);
         end
      end
      // One extra bit keeps ceil(N/2) exact for N = 2^p_width-1.
      half_d    = ({1'b0, div_cur_d} + (p_width+1)'(1)) >> 1;
      clk_out_d = ({1'b0, count_d} < half_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q       <= '0;
         div_cur_q     <= p_width'(p_default_div);
         pend_val_q    <= '0;
         div_pending_q <= 1'b0;
         clk_out_q     <= 1'b1;
      end else begin
         count_q       <= count_d;
         div_cur_q     <= div_cur_d;
         pend_val_q    <= pend_val_d;
         div_pending_q <= div_pending_d;
         clk_out_q     <= clk_out_d;
      end
   end

   assign tick        = wrap;
   assign clk_out     = clk_out_q;
   assign div_cur     = div_cur_q;
   assign div_pending = div_pending_q;

endmodule
